// File: rtl/raster_pkg.sv
// Shared types and constants for the raster walker.
// The scanner works on the integer pixel part of the 10.6 coordinates and
// re-attaches a pixel-centre fraction on the way out.
package raster_pkg;

  localparam int COORD_W = 16;
  localparam int FRAC_W  = 6;
  localparam int INT_W   = COORD_W - FRAC_W;

  // Fraction that places a coordinate at the centre of its pixel (0.5)
  localparam logic [FRAC_W-1:0] PIX_CENTER = 6'b100000;

  // Default screen resolution in pixels
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE,
    CLIP,
    SCAN
  } scan_state_t;

endpackage

// File: rtl/bbox_clip.sv
// Clips an integer-pixel bounding box against the last valid screen column
// and row, and flags boxes that cover no on-screen pixel.
// The bounds are unsigned, so only the upper edges ever need clamping.
module bbox_clip
  import raster_pkg::*;
(
  input  logic [INT_W-1:0] xmin,
  input  logic [INT_W-1:0] xmax,
  input  logic [INT_W-1:0] ymin,
  input  logic [INT_W-1:0] ymax,
  input  logic [INT_W-1:0] xlim,
  input  logic [INT_W-1:0] ylim,
  output logic [INT_W-1:0] cxmin,
  output logic [INT_W-1:0] cxmax,
  output logic [INT_W-1:0] cymin,
  output logic [INT_W-1:0] cymax,
  output logic             empty
);

  // Clamp the upper bounds and decide whether anything is left to walk.
  // xlim/ylim are inclusive (SCREEN_W-1, SCREEN_H-1), so a start coordinate
  // past them is the same as starting at or beyond the screen size.
  always_comb begin
    cxmin = xmin;
    cymin = ymin;
    cxmax = (xmax > xlim) ? xlim : xmax;
    cymax = (ymax > ylim) ? ylim : ymax;
    empty = (xmin > cxmax) || (ymin > cymax) ||
            (xmin > xlim)  || (ymin > ylim);
  end

endmodule

// File: rtl/bbox_scanner.sv
// Raster walker: accepts one bounding box, clips it to the screen and streams
// every covered pixel centre in raster order (x fastest) over valid/ready.
// Pixel outputs are driven straight from the cursor registers, so they stay
// put while the consumer stalls and there is no path from pix_ready to
// bbox_ready.
module bbox_scanner #(
  parameter int COORD_W  = raster_pkg::COORD_W,
  parameter int FRAC_W   = raster_pkg::FRAC_W,
  parameter int SCREEN_W = raster_pkg::SCREEN_W,
  parameter int SCREEN_H = raster_pkg::SCREEN_H
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bbox_valid,
  output logic               bbox_ready,
  input  logic [COORD_W-1:0] xmin,
  input  logic [COORD_W-1:0] xmax,
  input  logic [COORD_W-1:0] ymin,
  input  logic [COORD_W-1:0] ymax,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  output logic               done
);

  import raster_pkg::*;

  localparam int INT_BITS = COORD_W - FRAC_W;
  localparam logic [INT_BITS-1:0] X_LAST = INT_BITS'(SCREEN_W - 1);
  localparam logic [INT_BITS-1:0] Y_LAST = INT_BITS'(SCREEN_H - 1);

  scan_state_t state, state_nxt;

  // Integer bounds captured at accept time (fraction truncated = floor)
  logic [INT_BITS-1:0] bx_min, bx_max, by_min, by_max;

  // Clipped walk limits and the raster cursor
  logic [INT_BITS-1:0] cx_min, cx_max, cy_max;
  logic [INT_BITS-1:0] cx, cy;

  logic                done_q;
  logic                bbox_accept;
  logic                pix_fire;
  logic                at_last;

  logic [INT_BITS-1:0] clip_xmin, clip_xmax, clip_ymin, clip_ymax;
  logic                clip_empty;

  // Fraction bits of the incoming bounds are deliberately dropped
  logic                unused_frac;
  assign unused_frac = ^{xmin[FRAC_W-1:0], xmax[FRAC_W-1:0],
                         ymin[FRAC_W-1:0], ymax[FRAC_W-1:0]};

  bbox_clip u_clip (
    .xmin  (bx_min),
    .xmax  (bx_max),
    .ymin  (by_min),
    .ymax  (by_max),
    .xlim  (X_LAST),
    .ylim  (Y_LAST),
    .cxmin (clip_xmin),
    .cxmax (clip_xmax),
    .cymin (clip_ymin),
    .cymax (clip_ymax),
    .empty (clip_empty)
  );

  assign at_last = (cx == cx_max) && (cy == cy_max);
  assign done    = done_q;

  // State register; reset abandons whatever box was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and stream outputs, all derived from the current state
  // and cursor. bbox_ready is masked while reset is held so no box can be
  // offered into a scanner that is being cleared.
  always_comb begin
    state_nxt   = state;
    bbox_ready  = 1'b0;
    bbox_accept = 1'b0;
    pix_valid   = 1'b0;
    pix_last    = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    pix_fire    = 1'b0;

    case (state)
      IDLE: begin
        bbox_ready  = !rst;
        bbox_accept = bbox_valid && !rst;
        if (bbox_accept) begin
          state_nxt = CLIP;
        end
      end

      CLIP: begin
        state_nxt = clip_empty ? IDLE : SCAN;
      end

      SCAN: begin
        pix_valid = 1'b1;
        pix_last  = at_last;
        pix_x     = {cx, PIX_CENTER};
        pix_y     = {cy, PIX_CENTER};
        pix_fire  = pix_ready;
        if (pix_ready && at_last) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bound capture, cursor walk and the done pulse. done is raised on exactly
  // the transitions back to IDLE (empty clip or last pixel taken), so it can
  // never overlap a valid pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      bx_min <= '0;
      bx_max <= '0;
      by_min <= '0;
      by_max <= '0;
      cx_min <= '0;
      cx_max <= '0;
      cy_max <= '0;
      cx     <= '0;
      cy     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (bbox_accept) begin
        bx_min <= xmin[COORD_W-1:FRAC_W];
        bx_max <= xmax[COORD_W-1:FRAC_W];
        by_min <= ymin[COORD_W-1:FRAC_W];
        by_max <= ymax[COORD_W-1:FRAC_W];
      end

      if (state == CLIP) begin
        cx_min <= clip_xmin;
        cx_max <= clip_xmax;
        cy_max <= clip_ymax;
        cx     <= clip_xmin;
        cy     <= clip_ymin;
        if (clip_empty) begin
          done_q <= 1'b1;
        end
      end

      if (pix_fire) begin
        if (cx < cx_max) begin
          cx <= cx + INT_BITS'(1);
        end else begin
          cx <= cx_min;
          cy <= cy + INT_BITS'(1);
        end
        if (at_last) begin
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bbox_scanner.sv
// Self-checking bench for bbox_scanner: a table of directed boxes with
// hand-computed pixel counts and end points, randomized boxes compared
// against a list-of-pixels model, and a reset-in-the-middle-of-a-scan sequence.
module tb_bbox_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        bbox_valid;
  logic        bbox_ready;
  logic [15:0] xmin, xmax, ymin, ymax;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_x, pix_y;
  logic        pix_last;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] xmin, xmax, ymin, ymax;
    int          mode;
    int          count;
    logic [15:0] fx, fy, lx, ly;
  } vec_t;

  typedef struct {
    logic [15:0] x, y;
    logic        last;
  } pix_t;

  vec_t vecs[8];
  pix_t expq[$];

  bbox_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .bbox_valid (bbox_valid),
    .bbox_ready (bbox_ready),
    .xmin       (xmin),
    .xmax       (xmax),
    .ymin       (ymin),
    .ymax       (ymax),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_last   (pix_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Guard against a scanner that never returns to idle
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] x0, input logic [15:0] x1,
                               input logic [15:0] y0, input logic [15:0] y1);
    bbox_valid = 1'b1;
    xmin = x0;
    xmax = x1;
    ymin = y0;
    ymax = y1;
  endtask

  // Model: floor the bounds to pixels, clamp the far edges to the screen,
  // then list every pixel centre row by row.
  function automatic void buildModel(input logic [15:0] x0, input logic [15:0] x1,
                                     input logic [15:0] y0, input logic [15:0] y1);
    int px0, px1, py0, py1;
    pix_t p;
    expq.delete();
    px0 = int'(x0) / 64;
    px1 = int'(x1) / 64;
    py0 = int'(y0) / 64;
    py1 = int'(y1) / 64;
    if (px1 > 639) px1 = 639;
    if (py1 > 479) py1 = 479;
    for (int y = py0; y <= py1; y++) begin
      for (int x = px0; x <= px1; x++) begin
        p.x    = 16'(x * 64 + 32);
        p.y    = 16'(y * 64 + 32);
        p.last = (x == px1) && (y == py1);
        expq.push_back(p);
      end
    end
  endfunction

  // 0: always ready, 1: 1,0,0 repeating, 2: random with a forced accept
  function automatic logic readyFor(input int mode, input int k);
    if (mode == 1) return (k % 3) == 0;
    if (mode == 2) return ((k % 8) == 7) ? 1'b1 : 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic waitIdle();
    int w;
    w = 0;
    while (!bbox_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("bbox_ready_before_accept", 32'(bbox_ready), 32'd1);
  endtask

  // Offers one box, walks the expected pixel list and checks timing:
  // CLIP cycle quiet, pixels from T+2, done one cycle after the last one.
  task automatic runBox(input logic [15:0] x0, input logic [15:0] x1,
                        input logic [15:0] y0, input logic [15:0] y1,
                        input int mode, output int count,
                        output logic [15:0] fx, output logic [15:0] fy,
                        output logic [15:0] lx, output logic [15:0] ly);
    int   k;
    int   exp_n;
    pix_t p;
    buildModel(x0, x1, y0, y1);
    exp_n = expq.size();
    count = 0;
    fx = '0; fy = '0; lx = '0; ly = '0;
    @(posedge clk);
    #1;
    pix_ready = 1'b0;
    @(negedge clk);
    checkOutput("done_single_cycle", 32'(done), 32'd0);
    waitIdle();
    applyStimulus(x0, x1, y0, y1);
    @(posedge clk);
    #1;
    bbox_valid = 1'b0;
    @(negedge clk);
    checkOutput("clip_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("clip_bbox_ready", 32'(bbox_ready), 32'd0);
    checkOutput("clip_done", 32'(done), 32'd0);
    k = 0;
    while (expq.size() > 0) begin
      @(posedge clk);
      #1;
      pix_ready = readyFor(mode, k);
      @(negedge clk);
      p = expq[0];
      checkOutput("pix_valid", 32'(pix_valid), 32'd1);
      checkOutput("pix_x", 32'(pix_x), 32'(p.x));
      checkOutput("pix_y", 32'(pix_y), 32'(p.y));
      checkOutput("pix_last", 32'(pix_last), 32'(p.last));
      checkOutput("scan_done", 32'(done), 32'd0);
      checkOutput("scan_bbox_ready", 32'(bbox_ready), 32'd0);
      if (pix_ready) begin
        if (pix_valid) begin
          if (count == 0) begin
            fx = pix_x;
            fy = pix_y;
          end
          lx = pix_x;
          ly = pix_y;
          count++;
        end
        void'(expq.pop_front());
      end
      k++;
    end
    @(posedge clk);
    #1;
    pix_ready = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("done_bbox_ready", 32'(bbox_ready), 32'd1);
    checkOutput("model_pixel_count", 32'(count), 32'(exp_n));
  endtask

  int          cnt;
  logic [15:0] fx, fy, lx, ly;

  initial begin
    rst        = 1'b1;
    bbox_valid = 1'b0;
    pix_ready  = 1'b0;
    xmin = '0; xmax = '0; ymin = '0; ymax = '0;

    //            xmin     xmax     ymin     ymax     mode n  first x  first y  last x   last y
    vecs[0] = '{16'h00C0, 16'h0100, 16'h0140, 16'h0180, 0, 4, 16'h00E0, 16'h0160, 16'h0120, 16'h01A0};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0020, 16'h0020, 16'h0020, 16'h0020};
    vecs[2] = '{16'h00C0, 16'h0100, 16'h0140, 16'h0180, 1, 4, 16'h00E0, 16'h0160, 16'h0120, 16'h01A0};
    vecs[3] = '{16'h0100, 16'h00C0, 16'h0140, 16'h0180, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{16'hA000, 16'hAF00, 16'h0140, 16'h0180, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{16'h9F00, 16'hAF00, 16'h77C0, 16'h77C0, 0, 4, 16'h9F20, 16'h77E0, 16'h9FE0, 16'h77E0};
    vecs[6] = '{16'h00FF, 16'h013F, 16'h0001, 16'h003F, 1, 2, 16'h00E0, 16'h0020, 16'h0120, 16'h0020};
    vecs[7] = '{16'h0000, 16'h0010, 16'h7780, 16'hFFFF, 0, 2, 16'h0020, 16'h77A0, 16'h0020, 16'h77E0};

    // Reset: everything quiet and bbox_ready held low while rst is high
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_bbox_ready", 32'(bbox_ready), 32'd0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_pix_last", 32'(pix_last), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pix_x", 32'(pix_x), 32'd0);
    checkOutput("rst_pix_y", 32'(pix_y), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_bbox_ready", 32'(bbox_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      runBox(vecs[i].xmin, vecs[i].xmax, vecs[i].ymin, vecs[i].ymax,
             vecs[i].mode, cnt, fx, fy, lx, ly);
      checkOutput($sformatf("vec%0d_count", i), 32'(cnt), 32'(vecs[i].count));
      if (vecs[i].count > 0) begin
        checkOutput($sformatf("vec%0d_first_x", i), 32'(fx), 32'(vecs[i].fx));
        checkOutput($sformatf("vec%0d_first_y", i), 32'(fy), 32'(vecs[i].fy));
        checkOutput($sformatf("vec%0d_last_x", i), 32'(lx), 32'(vecs[i].lx));
        checkOutput($sformatf("vec%0d_last_y", i), 32'(ly), 32'(vecs[i].ly));
      end
    end

    // Random small boxes, biased toward the right/bottom screen edges
    for (int r = 0; r < 24; r++) begin
      int x0, y0, xe, ye;
      logic [15:0] rx0, rx1, ry0, ry1;
      x0 = (r % 2 == 0) ? int'($urandom_range(630, 645)) : int'($urandom_range(0, 639));
      y0 = (r % 4 < 2) ? int'($urandom_range(472, 485)) : int'($urandom_range(0, 479));
      xe = x0 + int'($urandom_range(0, 7)) - 2;
      ye = y0 + int'($urandom_range(0, 6)) - 1;
      if (xe < 0) xe = 0;
      if (ye < 0) ye = 0;
      rx0 = {10'(x0), 6'($urandom_range(0, 63))};
      rx1 = {10'(xe), 6'($urandom_range(0, 63))};
      ry0 = {10'(y0), 6'($urandom_range(0, 63))};
      ry1 = {10'(ye), 6'($urandom_range(0, 63))};
      runBox(rx0, rx1, ry0, ry1, r % 3, cnt, fx, fy, lx, ly);
    end

    // Reset during the second pixel of a 2x2 box
    @(posedge clk);
    #1;
    pix_ready = 1'b1;
    @(negedge clk);
    waitIdle();
    applyStimulus(16'h00C0, 16'h0100, 16'h0140, 16'h0180);
    @(posedge clk);
    #1;
    bbox_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_first_pix_x", 32'(pix_x), 32'h00E0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_second_pix_x", 32'(pix_x), 32'h0120);
    checkOutput("mid_rst_bbox_ready", 32'(bbox_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("mid_rst_pix_last", 32'(pix_last), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_pix_x", 32'(pix_x), 32'd0);
    checkOutput("mid_rst_pix_y", 32'(pix_y), 32'd0);
    checkOutput("mid_rst_bbox_ready_after", 32'(bbox_ready), 32'd1);
    @(posedge clk);
    #1;
    pix_ready = 1'b0;
    @(negedge clk);
    checkOutput("abandoned_no_done", 32'(done), 32'd0);
    checkOutput("abandoned_no_pixel", 32'(pix_valid), 32'd0);
    runBox(16'h9F00, 16'hAF00, 16'h77C0, 16'h77C0, 0, cnt, fx, fy, lx, ly);
    checkOutput("after_rst_count", 32'(cnt), 32'd4);
    checkOutput("after_rst_first_x", 32'(fx), 32'h9F20);
    checkOutput("after_rst_first_y", 32'(fy), 32'h77E0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
